// File: rtl/pad_gpio_ctrl.sv
// pad_gpio_ctrl: registered control stage for a bank of bidirectional pads.
// Drives pad data/tristate from core registers. Each returned pad value goes
// through a two-flop synchroniser, an optional per-bit glitch filter and a
// rise/fall edge detector that feeds the interrupt logic.
module pad_gpio_ctrl #(
    parameter int WIDTH       = 8,
    parameter int FILT_CYCLES = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] out_data,
    input  logic [WIDTH-1:0] out_en,
    input  logic             filt_en,
    output logic [WIDTH-1:0] pad_o,
    output logic [WIDTH-1:0] pad_t,
    input  logic [WIDTH-1:0] pad_i,
    output logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] rise_irq,
    output logic [WIDTH-1:0] fall_irq
);

    // Counter wide enough to hold FILT_CYCLES; the accept point is one below it
    // because the cycle that sees the last stable sample also commits it.
    localparam int            CW       = $clog2(FILT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

    logic [WIDTH-1:0] pad_o_reg;
    logic [WIDTH-1:0] pad_t_reg;
    logic [WIDTH-1:0] s1_reg;
    logic [WIDTH-1:0] s2_reg;
    logic [WIDTH-1:0] in_data_reg;
    logic [WIDTH-1:0] in_data_next;
    logic [WIDTH-1:0] rise_reg;
    logic [WIDTH-1:0] fall_reg;

    // Output path: register core value and enable; reset parks every pad hi-Z.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pad_o_reg <= '0;
            pad_t_reg <= '1;
        end else begin
            pad_o_reg <= out_data;
            pad_t_reg <= ~out_en;
        end
    end

    // Two-flop synchroniser for the asynchronous pad return value.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_reg <= '0;
            s2_reg <= '0;
        end else begin
            s1_reg <= pad_i;
            s2_reg <= s1_reg;
        end
    end

    // Per-bit glitch filter: each bit owns its own stability counter.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_filt
            logic [CW-1:0] cnt_reg;
            logic [CW-1:0] cnt_next;
            logic          bit_next;

            // Accept s2 immediately in bypass, otherwise only after it has
            // differed from the stored value for FILT_CYCLES samples in a row.
            always_comb begin
                bit_next = in_data_reg[gi];
                cnt_next = '0;
                if (!filt_en) begin
                    bit_next = s2_reg[gi];
                end else if (s2_reg[gi] != in_data_reg[gi]) begin
                    if (cnt_reg == CNT_LAST) begin
                        bit_next = s2_reg[gi];
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end

            // Counter state; reset discards any pending change.
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign in_data_next[gi] = bit_next;
        end
    endgenerate

    // Filtered value plus edge pulses, registered together so a pulse lines
    // up with the first cycle the new in_data is visible.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            in_data_reg <= '0;
            rise_reg    <= '0;
            fall_reg    <= '0;
        end else begin
            in_data_reg <= in_data_next;
            rise_reg    <= in_data_next & ~in_data_reg;
            fall_reg    <= ~in_data_next & in_data_reg;
        end
    end

    assign pad_o    = pad_o_reg;
    assign pad_t    = pad_t_reg;
    assign in_data  = in_data_reg;
    assign rise_irq = rise_reg;
    assign fall_irq = fall_reg;

endmodule

// File: tb/tb_pad_gpio_ctrl.sv
// Testbench for pad_gpio_ctrl: a cycle-by-cycle vector table for reset,
// output drive and bypass input, then hand-written filter corner sequences.
module tb_pad_gpio_ctrl;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] out_data;
    logic [7:0] out_en;
    logic       filt_en;
    logic [7:0] pad_o;
    logic [7:0] pad_t;
    logic [7:0] pad_i;
    logic [7:0] in_data;
    logic [7:0] rise_irq;
    logic [7:0] fall_irq;

    int n_vec  = 0;
    int n_fail = 0;

    pad_gpio_ctrl #(.WIDTH(8), .FILT_CYCLES(4)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .out_data (out_data),
        .out_en   (out_en),
        .filt_en  (filt_en),
        .pad_o    (pad_o),
        .pad_t    (pad_t),
        .pad_i    (pad_i),
        .in_data  (in_data),
        .rise_irq (rise_irq),
        .fall_irq (fall_irq)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst;
        logic [7:0] od;
        logic [7:0] oe;
        logic       fe;
        logic [7:0] pi;
        logic [7:0] x_pad_o;
        logic [7:0] x_pad_t;
        logic [7:0] x_in;
        logic [7:0] x_rise;
        logic [7:0] x_fall;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl [NV];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_in(input string tag, input int j,
                            input logic [7:0] e_in, input logic [7:0] e_r, input logic [7:0] e_f);
        check($sformatf("%s in_data j=%0d", tag, j), in_data, e_in);
        check($sformatf("%s rise j=%0d", tag, j), rise_irq, e_r);
        check($sformatf("%s fall j=%0d", tag, j), fall_irq, e_f);
        $display("%s j=%0d in_data=%02h rise=%02h fall=%02h", tag, j, in_data, rise_irq, fall_irq);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        step();
        step();
        RESET = 1'b0;
    endtask

    // Pulse pad_i[3] for len cycles with the filter on; expected is given per j.
    task automatic glitch_run(input int len, input logic accept);
        logic [7:0] e_in, e_r, e_f;
        for (int j = 0; j < 13; j++) begin
            pad_i = (j < len) ? 8'h08 : 8'h00;
            step();
            e_in = (accept && j >= 5 && j < 9) ? 8'h08 : 8'h00;
            e_r  = (accept && j == 5) ? 8'h08 : 8'h00;
            e_f  = (accept && j == 9) ? 8'h08 : 8'h00;
            check_in($sformatf("glitch%0d", len), j, e_in, e_r, e_f);
        end
    endtask

    initial begin
        // rst  od     oe     fe    pi     pad_o  pad_t  in     rise   fall
        tbl[0]  = '{1'b1, 8'hA5, 8'h3C, 1'b0, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00};
        tbl[1]  = '{1'b1, 8'h5A, 8'hC3, 1'b0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00};
        tbl[2]  = '{1'b0, 8'hA5, 8'h0F, 1'b0, 8'h00, 8'hA5, 8'hF0, 8'h00, 8'h00, 8'h00};
        tbl[3]  = '{1'b0, 8'hA5, 8'h0F, 1'b0, 8'h01, 8'hA5, 8'hF0, 8'h00, 8'h00, 8'h00};
        tbl[4]  = '{1'b0, 8'hA5, 8'h0F, 1'b0, 8'h01, 8'hA5, 8'hF0, 8'h00, 8'h00, 8'h00};
        tbl[5]  = '{1'b0, 8'hA5, 8'h0F, 1'b0, 8'h01, 8'hA5, 8'hF0, 8'h01, 8'h01, 8'h00};
        tbl[6]  = '{1'b0, 8'h3C, 8'hF0, 1'b0, 8'h01, 8'h3C, 8'h0F, 8'h01, 8'h00, 8'h00};
        tbl[7]  = '{1'b0, 8'h3C, 8'hF0, 1'b0, 8'h00, 8'h3C, 8'h0F, 8'h01, 8'h00, 8'h00};
        tbl[8]  = '{1'b0, 8'h3C, 8'hF0, 1'b0, 8'h00, 8'h3C, 8'h0F, 8'h01, 8'h00, 8'h00};
        tbl[9]  = '{1'b0, 8'h3C, 8'hF0, 1'b0, 8'h00, 8'h3C, 8'h0F, 8'h00, 8'h00, 8'h01};
        tbl[10] = '{1'b0, 8'h3C, 8'hF0, 1'b0, 8'h00, 8'h3C, 8'h0F, 8'h00, 8'h00, 8'h00};
        tbl[11] = '{1'b0, 8'hFF, 8'h81, 1'b0, 8'hC6, 8'hFF, 8'h7E, 8'h00, 8'h00, 8'h00};
        tbl[12] = '{1'b0, 8'hFF, 8'h81, 1'b0, 8'hC6, 8'hFF, 8'h7E, 8'h00, 8'h00, 8'h00};
        tbl[13] = '{1'b0, 8'hFF, 8'h81, 1'b0, 8'hC6, 8'hFF, 8'h7E, 8'hC6, 8'hC6, 8'h00};
        tbl[14] = '{1'b0, 8'h00, 8'hFF, 1'b0, 8'hC6, 8'h00, 8'h00, 8'hC6, 8'h00, 8'h00};
        tbl[15] = '{1'b0, 8'h00, 8'hFF, 1'b0, 8'h84, 8'h00, 8'h00, 8'hC6, 8'h00, 8'h00};
        tbl[16] = '{1'b0, 8'h00, 8'hFF, 1'b0, 8'h84, 8'h00, 8'h00, 8'hC6, 8'h00, 8'h00};
        tbl[17] = '{1'b0, 8'h00, 8'hFF, 1'b0, 8'h84, 8'h00, 8'h00, 8'h84, 8'h00, 8'h42};
        tbl[18] = '{1'b0, 8'h00, 8'hFF, 1'b0, 8'h84, 8'h00, 8'h00, 8'h84, 8'h00, 8'h00};

        RESET = 1'b1; out_data = '0; out_en = '0; filt_en = 1'b0; pad_i = '0;

        // Table: inputs applied before an edge, outputs checked just after it.
        for (int i = 0; i < NV; i++) begin
            RESET = tbl[i].rst; out_data = tbl[i].od; out_en = tbl[i].oe;
            filt_en = tbl[i].fe; pad_i = tbl[i].pi;
            step();
            check($sformatf("vec%0d pad_o", i), pad_o, tbl[i].x_pad_o);
            check($sformatf("vec%0d pad_t", i), pad_t, tbl[i].x_pad_t);
            check($sformatf("vec%0d in_data", i), in_data, tbl[i].x_in);
            check($sformatf("vec%0d rise", i), rise_irq, tbl[i].x_rise);
            check($sformatf("vec%0d fall", i), fall_irq, tbl[i].x_fall);
            $display("vec%0d pad_o=%02h pad_t=%02h in_data=%02h rise=%02h fall=%02h",
                     i, pad_o, pad_t, in_data, rise_irq, fall_irq);
        end

        // Reset with random inputs on every cycle.
        RESET = 1'b1;
        for (int j = 0; j < 3; j++) begin
            out_data = 8'($urandom); out_en = 8'($urandom);
            pad_i = 8'($urandom); filt_en = 1'($urandom);
            step();
            check($sformatf("rndrst pad_t j=%0d", j), pad_t, 8'hFF);
            check($sformatf("rndrst pad_o j=%0d", j), pad_o, 8'h00);
            check_in("rndrst", j, 8'h00, 8'h00, 8'h00);
        end
        RESET = 1'b0; out_en = 8'h0F; out_data = 8'hA5; pad_i = 8'h00; filt_en = 1'b0;
        step();
        check("release pad_t", pad_t, 8'hF0);
        check("release pad_o", pad_o, 8'hA5);
        step();
        step();
        check_in("release", 0, 8'h00, 8'h00, 8'h00);

        // Glitch reject (3 cycles) then accept (4 cycles) on bit 3.
        filt_en = 1'b1;
        step();
        glitch_run(3, 1'b0);
        glitch_run(4, 1'b1);

        // Falling edge on bit 7 with filt_en dropped mid-count.
        filt_en = 1'b0; pad_i = 8'h80;
        for (int j = 0; j < 4; j++) step();
        check_in("fall_setup", 0, 8'h80, 8'h00, 8'h00);
        filt_en = 1'b1; pad_i = 8'h00;
        for (int j = 0; j < 8; j++) begin
            if (j == 4) filt_en = 1'b0;
            step();
            check_in("midtoggle", j,
                     (j < 4) ? 8'h80 : 8'h00, 8'h00, (j == 4) ? 8'h80 : 8'h00);
        end

        // Reset mid-filter on bit 4 with cnt at 2, then full re-acceptance.
        filt_en = 1'b1; out_en = 8'hFF; out_data = 8'h5A; pad_i = 8'h10;
        for (int j = 0; j < 13; j++) begin
            RESET = (j == 4);
            step();
            check($sformatf("rstmid pad_t j=%0d", j), pad_t, (j == 4) ? 8'hFF : 8'h00);
            check($sformatf("rstmid pad_o j=%0d", j), pad_o, (j == 4) ? 8'h00 : 8'h5A);
            check_in("rstmid", j, (j >= 10) ? 8'h10 : 8'h00,
                     (j == 10) ? 8'h10 : 8'h00, 8'h00);
        end
        RESET = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
